// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and frame defaults,
// common to the receiver and the transmitter.
package uart_pkg;
    localparam int OVERSAMPLE  = 16;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, no parity; samples each bit at its centre
// and reports the byte, a one-cycle done pulse and a stop-bit framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk_100MHz,
    input  logic            rst,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .d          (rx),
        .q          (rx_s)
    );

    uart_state_t     state, state_n;
    logic [3:0]      s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic [DBIT-1:0] dout_n;
    logic            frame_err_n;
    logic            done_n;

    always_comb begin
        state_n     = state;
        s_n         = s;
        n_n         = n;
        b_n         = b;
        dout_n      = dout;
        frame_err_n = frame_err;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == 4'd7) begin
                        // A start bit that is gone by mid-bit is a glitch, not a frame.
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == 4'd15) begin
                        s_n = '0;
                        b_n = {rx_s, b[DBIT-1:1]};
                        n_n = n + 1'b1;
                        if (n == NW'(DBIT - 1))
                            state_n = STOP;
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == 4'(SB_TICK - 1)) begin
                        state_n     = IDLE;
                        dout_n      = b;
                        frame_err_n = ~rx_s;
                        done_n      = 1'b1;
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            dout         <= dout_n;
            frame_err    <= frame_err_n;
            rx_done_tick <= done_n;
        end
    end
endmodule
